cordic: RTL and testbench
=========================

# cordic

Pipelined rotation-mode CORDIC producing cosine and sine of a 32-bit binary angle. It rotates a 16-bit input vector (Xin, Yin) by the angle, one new angle accepted per clock, and serves as the sin/cos generator for downstream DSP logic. Outputs include the CORDIC gain (≈1.6468); callers pre-scale Xin by 1/1.6468 to get unit-scaled results.

## Interface
- WIDTH, 16, bit width of Xin/Yin/COSout/SINout; also the number of iteration stages
- ANGLE_WIDTH, 32, angle width; fixed at 32 (full circle = 2^32)
- clk  input  1  rising-edge clock
- nreset  input  1  synchronous, active-high reset (1 = reset)
- COSout  output  WIDTH  signed; final X = Xin·K·cos(θ) − Yin·K·sin(θ)
- SINout  output  WIDTH  signed; final Y = Xin·K·sin(θ) + Yin·K·cos(θ)
- Xin  input  WIDTH  signed initial X
- Yin  input  WIDTH  signed initial Y
- angle  input  32  unsigned binary angle θ; 0x40000000 = 90°, wraps modulo 2^32

## Operation
- Stage 0 (pre-rotation) selects on angle[31:30], mapping θ into [−90°, +90°]:
  - 00 or 11: x=Xin, y=Yin, z=angle.
  - 01: x=−Yin, y=Xin, z=angle−0x40000000.
  - 10: x=Yin, y=−Xin, z=angle+0x40000000.
- Stages i=0..WIDTH−1, with d = +1 if z ≥ 0 (signed), else −1:
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan_i.
  - atan_i = round(atan(2^−i)·2^32/2π).
- x/y datapath is WIDTH+1 bits signed (sign-extend inputs) to absorb gain growth; >>> is arithmetic shift; z is 32-bit signed, wraps.
- Output: low WIDTH bits of final x/y (two's-complement wrap).
- Yin=0 and Xin=round(32000/1.647)=19429 yields COSout≈32000·cos θ, SINout≈32000·sin θ.

## Timing
- Every stage is registered; latency = WIDTH+1 cycles (17 by default) from angle/Xin/Yin sampled to COSout/SINout; throughput one input per cycle, no handshake, no stall.
- Inputs are sampled every rising edge, with no enable.
- Reset: when nreset=1 at a rising edge, all pipeline registers clear to 0, so COSout=SINout=0 the following cycle.
- Reset mid-stream discards all in-flight samples. The first valid output appears WIDTH+1 cycles after the first edge with nreset=0.
- Angle wrap-around (0xFFFFFFFF→0) is seamless: no special case, consecutive results continuous.
- Quadrant boundaries 0x40000000, 0x80000000 and 0xC0000000 must not glitch; the pre-rotation choice is exact at each.

## Configuration
- CORDIC_SAT_EN:
  - Defined: final x/y saturate to the WIDTH-bit signed range [−2^(WIDTH−1), 2^(WIDTH−1)−1] before registering the output.
  - Undefined: plain truncation (wrap).
  - Identical results whenever the magnitude stays in range.

## Structure
- Package cordic_pkg holds:
  - the 32-entry atan table constants (0x20000000, 0x12E4051D, 0x09FB385B, 0x051111D4, 0x028B0D43, …);
  - the quadrant constants 0x40000000/0x80000000;
  - the gain constant K≈1.64676.
- One sub-module, cordic_stage: a parameterised shift index i, one registered micro-rotation (x, y, z in → x, y, z out), instantiated WIDTH times via generate.

## Test plan
- Angle 0x00000000, Xin=19429, Yin=0 → after 17 cycles COSout≈32000, SINout≈0 (±10 LSB).
- Angle 0x20000000 (45°) → COSout≈SINout≈22627 (±10); angle 0x35555555 (75°) → COSout≈8282, SINout≈30910.
- Quadrants:
  - 0x40000000 → COSout≈0, SINout≈32000.
  - 0x80000000 → COSout≈−32000, SINout≈0.
  - 0xC0000000 → COSout≈0, SINout≈−32000.
- Sweep: angle starts 0 and increments by 0x00400000 each cycle for 1000 cycles. Each output matches a real-valued model of the angle applied 17 cycles earlier within ±10 LSB, including across wrap.
- Reset: hold nreset=1 for 5 cycles mid-sweep → outputs 0 from the cycle after the first reset edge; the first nonzero valid result appears 17 cycles after release.
- With CORDIC_SAT_EN, Xin=32767, Yin=0, angle 0 → COSout=32767 (saturated), SINout≈0. Without it the output wraps negative.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined rotation-mode CORDIC: binary-angle
// quadrant constants, the arctangent table and the nominal CORDIC gain.
package cordic_pkg;

  // Binary angle: full circle = 2^32.
  localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;
  localparam logic [31:0] HALF_TURN    = 32'h8000_0000;

  // Nominal gain of the micro-rotation chain; callers pre-scale Xin by 1/K.
  localparam real CORDIC_GAIN = 1.64676;

  // atan(2^-i) as a binary angle, rounded to nearest.
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // Quadrant of the input angle, taken from its top two bits.
  typedef enum logic [1:0] {
    QUAD_0   = 2'b00,
    QUAD_90  = 2'b01,
    QUAD_180 = 2'b10,
    QUAD_270 = 2'b11
  } quad_e;

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with shift index SHIFT.
// Rotates (x, y) by +/-atan(2^-SHIFT) in the direction that drives z to 0.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [31:0]       z_in,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic signed [31:0]       z_out
);

  localparam logic signed [31:0] ATAN_I = ATAN_TABLE[SHIFT];

  logic signed [DATA_W-1:0] x_sh;
  logic signed [DATA_W-1:0] y_sh;

  assign x_sh = x_in >>> SHIFT;
  assign y_sh = y_in >>> SHIFT;

  // Micro-rotation: positive residual angle rotates counter-clockwise.
  always_ff @(posedge clk) begin
    if (nreset) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (!z_in[31]) begin
      x_out <= x_in - y_sh;
      y_out <= y_in + x_sh;
      z_out <= z_in - ATAN_I;
    end else begin
      x_out <= x_in + y_sh;
      y_out <= y_in - x_sh;
      z_out <= z_in + ATAN_I;
    end
  end

endmodule

// File: rtl/cordic.sv
// Pipelined rotation-mode CORDIC: rotates (Xin, Yin) by a 32-bit binary angle.
// Latency WIDTH+1 cycles, one sample per clock, no handshake.
// Optional build macro CORDIC_SAT_EN: saturate the outputs to the WIDTH-bit
// signed range instead of wrapping.
module cordic
  import cordic_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    nreset,
  output logic signed [WIDTH-1:0] COSout,
  output logic signed [WIDTH-1:0] SINout,
  input  logic signed [WIDTH-1:0] Xin,
  input  logic signed [WIDTH-1:0] Yin,
  input  logic [ANGLE_WIDTH-1:0]  angle
);

  // One guard bit absorbs the ~1.65x gain growth and the negation of -2^(W-1).
  localparam int XW = WIDTH + 1;

`ifdef CORDIC_SAT_EN
  localparam logic signed [XW-1:0] SAT_HI = XW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = -SAT_HI - XW'(1);
`endif

  // Reduce the final XW-bit value to the WIDTH-bit output.
  function automatic logic signed [WIDTH-1:0] fit_out(input logic signed [XW-1:0] v);
`ifdef CORDIC_SAT_EN
    if (v > SAT_HI)      return WIDTH'(SAT_HI);
    else if (v < SAT_LO) return WIDTH'(SAT_LO);
    else                 return WIDTH'(v);
`else
    return WIDTH'(v);
`endif
  endfunction

  logic signed [XW-1:0] x_ext, y_ext;
  logic signed [XW-1:0] x_pre, y_pre;
  logic signed [31:0]   z_pre;
  logic signed [XW-1:0] x_p0, y_p0;
  logic signed [31:0]   z_p0;
  logic signed [XW-1:0] x_s [0:WIDTH-1];
  logic signed [XW-1:0] y_s [0:WIDTH-1];
  logic signed [31:0]   z_s [0:WIDTH-1];

  assign x_ext = XW'(Xin);
  assign y_ext = XW'(Yin);

  // Pre-rotation by a multiple of 90 degrees folds theta into [-90, +90].
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = angle;
    case (quad_e'(angle[31:30]))
      QUAD_90: begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = angle - QUARTER_TURN;
      end
      QUAD_180: begin
        // Subtracting 270 degrees is the same binary angle as adding 90.
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = angle - (HALF_TURN + QUARTER_TURN);
      end
      default: ;
    endcase
  end

  // ---- stage p0: pre-rotation register ----
  // Capture the quadrant-folded vector and residual angle every clock.
  always_ff @(posedge clk) begin
    if (nreset) begin
      x_p0 <= '0;
      y_p0 <= '0;
      z_p0 <= '0;
    end else begin
      x_p0 <= x_pre;
      y_p0 <= y_pre;
      z_p0 <= z_pre;
    end
  end

  // ---- stages 1..WIDTH: micro-rotation chain ----
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      cordic_stage #(.DATA_W(XW), .SHIFT(i)) u_stage (
        .clk    (clk),
        .nreset (nreset),
        .x_in   (x_p0),
        .y_in   (y_p0),
        .z_in   (z_p0),
        .x_out  (x_s[i]),
        .y_out  (y_s[i]),
        .z_out  (z_s[i])
      );
    end else begin : g_rest
      cordic_stage #(.DATA_W(XW), .SHIFT(i)) u_stage (
        .clk    (clk),
        .nreset (nreset),
        .x_in   (x_s[i-1]),
        .y_in   (y_s[i-1]),
        .z_in   (z_s[i-1]),
        .x_out  (x_s[i]),
        .y_out  (y_s[i]),
        .z_out  (z_s[i])
      );
    end
  end

  // ---- output: final stage reduced to WIDTH bits ----
  assign COSout = fit_out(x_s[WIDTH-1]);
  assign SINout = fit_out(y_s[WIDTH-1]);

endmodule

// File: tb/tb_cordic.sv
// Self-checking bench for cordic: directed angles, a phase sweep with a
// mid-stream reset, random vectors and a saturation probe, all compared
// against a real-valued rotation model.
module tb_cordic;
  import cordic_pkg::*;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH + 1;
  localparam int NH    = 4096;
  localparam int TOL   = 10;
  localparam int LTOL  = 16;  // nominal 32000-scale values; 19429*K is ~31995

  logic                    clk = 1'b0;
  logic                    nreset;
  logic signed [WIDTH-1:0] COSout, SINout;
  logic signed [WIDTH-1:0] Xin, Yin;
  logic [31:0]             angle;

  always #5 clk = ~clk;

  cordic #(.WIDTH(WIDTH), .ANGLE_WIDTH(32)) dut (
    .clk    (clk),
    .nreset (nreset),
    .COSout (COSout),
    .SINout (SINout),
    .Xin    (Xin),
    .Yin    (Yin),
    .angle  (angle)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  real gain_k;

  logic [31:0] h_ang [NH];
  int          h_x   [NH];
  int          h_y   [NH];
  bit          h_rst [NH];
  bit          h_lit [NH];
  int          h_lc  [NH];
  int          h_ls  [NH];
  bit          h_sat [NH];

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    if ((obs - exp > tol) || (exp - obs > tol)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Real value to the WIDTH-bit output format (clamp or two's-complement wrap).
  function automatic int fit16(input real r);
    int v;
    logic signed [15:0] w;
    v = int'(r);
`ifdef CORDIC_SAT_EN
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
`else
    w = v[15:0];
    return int'(w);
`endif
  endfunction

  // Ideal rotation of (x, y) by the binary angle a, including the gain.
  task automatic model(input logic [31:0] a, input int x, input int y,
                       output int ec, output int es);
    real th;
    th = real'(longint'({32'b0, a})) * 2.0 * 3.14159265358979 / 4294967296.0;
    ec = fit16(gain_k * (real'(x) * $cos(th) - real'(y) * $sin(th)));
    es = fit16(gain_k * (real'(x) * $sin(th) + real'(y) * $cos(th)));
  endtask

  // Check the outputs present after edge number cyc.
  task automatic evaluate();
    int  s;
    bit  zero;
    int  ec, es;
    s    = cyc - (LAT - 1);
    zero = 1'b0;
    for (int k = s; k <= cyc; k++)
      if (k < 1 || h_rst[k]) zero = 1'b1;
    if (zero) begin
      chk($sformatf("rst_cos@%0d", cyc), COSout, 0, 0);
      chk($sformatf("rst_sin@%0d", cyc), SINout, 0, 0);
    end else begin
      model(h_ang[s], h_x[s], h_y[s], ec, es);
      chk($sformatf("cos a=%08h x=%0d y=%0d", h_ang[s], h_x[s], h_y[s]), COSout, ec, TOL);
      chk($sformatf("sin a=%08h x=%0d y=%0d", h_ang[s], h_x[s], h_y[s]), SINout, es, TOL);
      if (h_lit[s]) begin
        chk($sformatf("nom_cos a=%08h", h_ang[s]), COSout, h_lc[s], LTOL);
        chk($sformatf("nom_sin a=%08h", h_ang[s]), SINout, h_ls[s], LTOL);
      end
      if (h_sat[s]) begin
`ifdef CORDIC_SAT_EN
        chk("sat_cos", COSout, 32767, 0);
`else
        chk("wrap_cos_negative", int'(COSout < 0), 1, 0);
`endif
      end
    end
  endtask

  task automatic step(input logic [31:0] a, input int x, input int y, input bit r,
                      input bit lit, input int lc, input int ls, input bit satp);
    angle  = a;
    Xin    = 16'(x);
    Yin    = 16'(y);
    nreset = r;
    @(posedge clk);
    cyc++;
    if (cyc >= NH) begin
      $display("FAIL history_overflow: cycle %0d exceeds %0d", cyc, NH);
      $fatal(1, "history overflow");
    end
    h_ang[cyc] = a;
    h_x[cyc]   = x;
    h_y[cyc]   = y;
    h_rst[cyc] = r;
    h_lit[cyc] = lit;
    h_lc[cyc]  = lc;
    h_ls[cyc]  = ls;
    h_sat[cyc] = satp;
    #1;
    evaluate();
  endtask

  logic [31:0] dir_ang [6];
  int          dir_c   [6];
  int          dir_s   [6];
  logic [31:0] edge_ang [7];

  initial begin
    gain_k = 1.0;
    for (int i = 0; i < WIDTH; i++) gain_k = gain_k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    $display("info: reference gain %f, package gain %f", gain_k, CORDIC_GAIN);

    dir_ang = '{32'h0000_0000, 32'h2000_0000, 32'h3555_5555,
                QUARTER_TURN, HALF_TURN, HALF_TURN | QUARTER_TURN};
    dir_c   = '{32000, 22627, 8282, 0, -32000, 0};
    dir_s   = '{0, 22627, 30910, 32000, 0, -32000};
    edge_ang = '{32'h3FFF_FFFF, 32'h4000_0001, 32'h7FFF_FFFF, 32'h8000_0001,
                 32'hBFFF_FFFF, 32'hC000_0001, 32'hFFFF_FFFF};

    // Initial reset.
    for (int i = 0; i < 4; i++) step(32'h1234_5678, 1000, -1000, 1'b1, 1'b0, 0, 0, 1'b0);

    // Directed angles with nominal values, then quadrant-boundary neighbours.
    for (int i = 0; i < 6; i++) step(dir_ang[i], 19429, 0, 1'b0, 1'b1, dir_c[i], dir_s[i], 1'b0);
    for (int i = 0; i < 7; i++) step(edge_ang[i], 19429, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Phase sweep across the wrap point, with a 5-cycle reset in the middle.
    for (int i = 0; i < 1040; i++) begin
      logic [31:0] a;
      a = 32'(i) * 32'h0040_0000;
      step(a, 19429, 0, (i >= 500 && i < 505), 1'b0, 0, 0, 1'b0);
    end

    // Random vectors and angles.
    for (int i = 0; i < 300; i++) begin
      int x, y;
      x = int'($urandom_range(26000, 0)) - 13000;
      y = int'($urandom_range(26000, 0)) - 13000;
      step($urandom, x, y, 1'b0, 1'b0, 0, 0, 1'b0);
    end

    // Full-scale inputs: outputs exceed the WIDTH-bit range.
    step(32'h0000_0000, 32767, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    step(QUARTER_TURN, -32768, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Drain the pipeline.
    for (int i = 0; i < LAT + 3; i++) step($urandom, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
